// File: rtl/msg_axis_pkg.sv
// Shared types and elaboration helpers for the message AXI-Stream framer
// and the checksum accumulator it shares with the RX checker.
package msg_axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int CHK_W   = 8;
  localparam int MAX_BPB = 128;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Low R lanes of the final beat are valid; a full final beat keeps every lane.
  function automatic logic [MAX_BPB-1:0] last_keep(input int t, input int bpb);
    logic [MAX_BPB-1:0] mask;
    int                 r;
    r = t % bpb;
    if (r == 0) r = bpb;
    mask = '0;
    for (int i = 0; i < MAX_BPB; i++) begin
      if (i < r) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/byte_sum_acc.sv
// Modulo-256 accumulator that folds one beat slice of bytes per enabled cycle,
// counting only lanes whose mask bit is set.
module byte_sum_acc
  import msg_axis_pkg::*;
#(
  parameter int BPB = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               en,
  input  logic [BPB*8-1:0]   slice,
  input  logic [BPB-1:0]     lane_mask,
  output logic [CHK_W-1:0]   sum_next
);

  logic [CHK_W-1:0] acc_q;

  always_comb begin
    sum_next = acc_q;
    for (int j = 0; j < BPB; j++) begin
      if (lane_mask[j]) sum_next = sum_next + slice[j*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    acc_q <= '0;
    else if (clear) acc_q <= '0;
    else if (en)    acc_q <= sum_next;
  end

endmodule

// File: rtl/msg_axis_framer.sv
// Captures a flat message on start, optionally appends an additive checksum,
// and streams it out as AXI4-Stream beats with backpressure and exact tkeep.
module msg_axis_framer
  import msg_axis_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int MSG_BYTES = 79,
  parameter int CHK_EN    = 1,
  localparam int BPB      = DATA_W / 8,
  localparam int T        = MSG_BYTES + CHK_EN,
  localparam int NBEATS   = ceil_div(T, BPB),
  localparam int BIDX_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [MSG_BYTES*8-1:0] msg,
  output logic                   busy,
  output logic                   done,
  input  logic                   tready,
  output logic                   tvalid,
  output logic [DATA_W-1:0]      tdata,
  output logic [BPB-1:0]         tkeep,
  output logic [BPB-1:0]         tstrb,
  output logic                   tlast,
  output logic [BIDX_W-1:0]      beat_idx
);

  localparam int BUF_BYTES = NBEATS * BPB;
  localparam int BUF_W     = BUF_BYTES * 8;
  // Clamped so the checksum write stays in range when CHK_EN=0 and the frame is beat-aligned.
  localparam int CHK_POS   = (MSG_BYTES < BUF_BYTES) ? MSG_BYTES : BUF_BYTES - 1;
  localparam logic [MAX_BPB-1:0] KEEP_FULL = last_keep(T, BPB);
  localparam logic [BPB-1:0]     LAST_KEEP = KEEP_FULL[BPB-1:0];
  localparam logic [BIDX_W-1:0]  LAST_IDX  = BIDX_W'(NBEATS - 1);

  state_t              state, state_next;
  logic [BUF_W-1:0]    buf_q;
  logic [BIDX_W-1:0]   calc_cnt;
  logic [DATA_W-1:0]   calc_slice, send_slice;
  logic [BPB-1:0]      calc_mask;
  logic [CHK_W-1:0]    sum_next;
  logic                calc_last, send_last, handshake;

  assign calc_last = (calc_cnt == LAST_IDX);
  assign send_last = (beat_idx == LAST_IDX);
  assign handshake = (state == SEND) && tready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (CHK_EN != 0) ? CALC : SEND;
      CALC: if (calc_last) state_next = SEND;
      SEND: if (handshake && send_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    tvalid = (state == SEND);
    tlast  = tvalid && send_last;
    tkeep  = '0;
    if (tvalid) tkeep = send_last ? LAST_KEEP : '1;
    tstrb  = tkeep;
    send_slice = buf_q[beat_idx*DATA_W +: DATA_W];
    tdata  = '0;
    for (int j = 0; j < BPB; j++) begin
      if (tkeep[j]) tdata[j*8 +: 8] = send_slice[j*8 +: 8];
    end
  end

  // The checksum lane and padding are excluded from the sum.
  always_comb begin
    calc_slice = buf_q[calc_cnt*DATA_W +: DATA_W];
    calc_mask  = '0;
    for (int j = 0; j < BPB; j++) begin
      calc_mask[j] = (int'(calc_cnt) * BPB + j) < MSG_BYTES;
    end
  end

  byte_sum_acc #(.BPB(BPB)) u_sum (
    .clk       (clk),
    .resetn    (resetn),
    .clear     ((state == IDLE) && start),
    .en        (state == CALC),
    .slice     (calc_slice),
    .lane_mask (calc_mask),
    .sum_next  (sum_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_q    <= '0;
      beat_idx <= '0;
      calc_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= handshake && send_last;
      case (state)
        IDLE: begin
          if (start) begin
            buf_q    <= BUF_W'(msg);
            beat_idx <= '0;
            calc_cnt <= '0;
          end
        end
        CALC: begin
          calc_cnt <= calc_cnt + 1'b1;
          if (calc_last && (CHK_EN != 0)) buf_q[CHK_POS*8 +: 8] <= sum_next;
        end
        SEND: begin
          if (handshake) beat_idx <= send_last ? '0 : beat_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_axis_framer.sv
// Directed bench: default 256/79/1 framer plus the 64/16/1 and 256/64/0 variants.
module tb_msg_axis_framer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic         d_start, d_tready, d_busy, d_done, d_tvalid, d_tlast;
  logic [631:0] d_msg;
  logic [255:0] d_tdata;
  logic [31:0]  d_tkeep, d_tstrb;
  logic [1:0]   d_beat_idx;

  logic         a_start, a_tready, a_busy, a_done, a_tvalid, a_tlast;
  logic [127:0] a_msg;
  logic [63:0]  a_tdata;
  logic [7:0]   a_tkeep, a_tstrb;
  logic [1:0]   a_beat_idx;

  logic         b_start, b_tready, b_busy, b_done, b_tvalid, b_tlast;
  logic [511:0] b_msg;
  logic [255:0] b_tdata;
  logic [31:0]  b_tkeep, b_tstrb;
  logic [0:0]   b_beat_idx;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  msg_axis_framer u_dflt (
    .clk(clk), .resetn(resetn), .start(d_start), .msg(d_msg), .busy(d_busy), .done(d_done),
    .tready(d_tready), .tvalid(d_tvalid), .tdata(d_tdata), .tkeep(d_tkeep), .tstrb(d_tstrb),
    .tlast(d_tlast), .beat_idx(d_beat_idx)
  );

  msg_axis_framer #(.DATA_W(64), .MSG_BYTES(16), .CHK_EN(1)) u_var_a (
    .clk(clk), .resetn(resetn), .start(a_start), .msg(a_msg), .busy(a_busy), .done(a_done),
    .tready(a_tready), .tvalid(a_tvalid), .tdata(a_tdata), .tkeep(a_tkeep), .tstrb(a_tstrb),
    .tlast(a_tlast), .beat_idx(a_beat_idx)
  );

  msg_axis_framer #(.DATA_W(256), .MSG_BYTES(64), .CHK_EN(0)) u_var_b (
    .clk(clk), .resetn(resetn), .start(b_start), .msg(b_msg), .busy(b_busy), .done(b_done),
    .tready(b_tready), .tvalid(b_tvalid), .tdata(b_tdata), .tkeep(b_tkeep), .tstrb(b_tstrb),
    .tlast(b_tlast), .beat_idx(b_beat_idx)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Default-instance stream model: message bytes, then the 8-bit sum, then zero padding.
  function automatic logic [255:0] exp_beat_d(input logic [631:0] m, input int b);
    logic [255:0] r;
    logic [7:0]   chk;
    int           idx;
    chk = 8'h00;
    for (int i = 0; i < 79; i++) chk = chk + m[i*8 +: 8];
    r = '0;
    for (int j = 0; j < 32; j++) begin
      idx = b * 32 + j;
      if (idx < 79)       r[j*8 +: 8] = m[idx*8 +: 8];
      else if (idx == 79) r[j*8 +: 8] = chk;
    end
    return r;
  endfunction

  task automatic recv_frame_d(input logic [631:0] m, input int stall_beat, input bit poke_start);
    int waited = 0;
    while (!d_tvalid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("d_tvalid_arrive", 256'(d_tvalid), 256'(1));
    for (int b = 0; b < 3; b++) begin
      if (b == stall_beat) begin
        d_tready = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("d_stall_tdata", d_tdata, exp_beat_d(m, b));
          check("d_stall_beat_idx", 256'(d_beat_idx), 256'(b));
          check("d_stall_tvalid", 256'(d_tvalid), 256'(1));
        end
        d_tready = 1'b1;
      end
      if (poke_start && b == 1) begin
        d_start = 1'b1;
        d_msg   = ~m;
      end
      check("d_beat_idx", 256'(d_beat_idx), 256'(b));
      check("d_tdata", d_tdata, exp_beat_d(m, b));
      check("d_tkeep", 256'(d_tkeep), (b == 2) ? 256'h0000FFFF : 256'hFFFFFFFF);
      check("d_tstrb", 256'(d_tstrb), (b == 2) ? 256'h0000FFFF : 256'hFFFFFFFF);
      check("d_tlast", 256'(d_tlast), (b == 2) ? 256'(1) : 256'(0));
      check("d_busy_send", 256'(d_busy), 256'(1));
      @(negedge clk);
      d_start = 1'b0;
    end
    check("d_done_pulse", 256'(d_done), 256'(1));
    check("d_busy_end", 256'(d_busy), 256'(0));
    check("d_tvalid_end", 256'(d_tvalid), 256'(0));
    check("d_tlast_end", 256'(d_tlast), 256'(0));
    check("d_tdata_end", d_tdata, 256'(0));
    check("d_tkeep_end", 256'(d_tkeep), 256'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [631:0] msg_01, msg_ff, msg_seq;
    int           waited;

    msg_01 = {79{8'h01}};
    msg_ff = {79{8'hFF}};
    for (int i = 0; i < 79; i++) msg_seq[i*8 +: 8] = 8'(i);

    d_start = 0; a_start = 0; b_start = 0;
    d_tready = 1; a_tready = 1; b_tready = 1;
    d_msg = '0; a_msg = '0; b_msg = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #11;
    check("rst_tvalid", 256'(d_tvalid), 256'(0));
    check("rst_busy", 256'(d_busy), 256'(0));
    check("rst_done", 256'(d_done), 256'(0));
    check("rst_tlast", 256'(d_tlast), 256'(0));
    check("rst_tdata", d_tdata, 256'(0));
    check("rst_tkeep", 256'(d_tkeep), 256'(0));
    check("rst_tstrb", 256'(d_tstrb), 256'(0));
    check("rst_beat_idx", 256'(d_beat_idx), 256'(0));
    @(negedge clk);
    resetn = 1'b1;

    // Frame of 0x01 bytes: exact checksum latency, then three beats.
    @(negedge clk);
    d_msg = msg_01; d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    check("d_busy_calc", 256'(d_busy), 256'(1));
    check("d_lat_n1", 256'(d_tvalid), 256'(0));
    @(negedge clk);
    check("d_lat_n2", 256'(d_tvalid), 256'(0));
    @(negedge clk);
    check("d_lat_n3", 256'(d_tvalid), 256'(0));
    @(negedge clk);
    check("d_lat_n4", 256'(d_tvalid), 256'(1));
    check("d_first_tdata", d_tdata, {32{8'h01}});
    recv_frame_d(msg_01, -1, 1'b0);
    @(negedge clk);
    check("d_done_one_cycle", 256'(d_done), 256'(0));

    // 0xFF bytes with backpressure on beat 1; start in the done cycle is taken.
    d_msg = msg_ff; d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    recv_frame_d(msg_ff, 1, 1'b0);
    d_msg = msg_01; d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    check("d_start_in_done", 256'(d_busy), 256'(1));
    recv_frame_d(msg_01, -1, 1'b0);
    @(negedge clk);

    // Restarts during CALC and SEND must be ignored.
    d_msg = msg_seq; d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    d_msg = ~msg_seq; d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    check("d_busy_after_poke", 256'(d_busy), 256'(1));
    recv_frame_d(msg_seq, -1, 1'b1);
    @(negedge clk);
    check("d_no_restart_busy", 256'(d_busy), 256'(0));
    check("d_no_restart_tvalid", 256'(d_tvalid), 256'(0));

    // Asynchronous reset while beat 1 is pending, then a clean frame.
    d_msg = msg_seq; d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    waited = 0;
    while (!d_tvalid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    d_tready = 1'b0;
    check("d_pend_beat_idx", 256'(d_beat_idx), 256'(1));
    #2 resetn = 1'b0;
    #1;
    check("d_arst_tvalid", 256'(d_tvalid), 256'(0));
    check("d_arst_busy", 256'(d_busy), 256'(0));
    check("d_arst_tlast", 256'(d_tlast), 256'(0));
    check("d_arst_beat_idx", 256'(d_beat_idx), 256'(0));
    @(negedge clk);
    resetn = 1'b1; d_tready = 1'b1;
    @(negedge clk);
    d_msg = msg_ff; d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    recv_frame_d(msg_ff, -1, 1'b0);
    @(negedge clk);

    // 64-bit beats, 16 bytes + checksum: 0+1+...+15 = 120 = 0x78 alone on beat 2.
    for (int i = 0; i < 16; i++) a_msg[i*8 +: 8] = 8'(i);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("a_lat_n3", 256'(a_tvalid), 256'(0));
    @(negedge clk);
    check("a_lat_n4", 256'(a_tvalid), 256'(1));
    check("a_b0_tdata", 256'(a_tdata), 256'h0706050403020100);
    check("a_b0_tkeep", 256'(a_tkeep), 256'hFF);
    check("a_b0_tlast", 256'(a_tlast), 256'(0));
    @(negedge clk);
    check("a_b1_tdata", 256'(a_tdata), 256'h0F0E0D0C0B0A0908);
    check("a_b1_beat_idx", 256'(a_beat_idx), 256'(1));
    @(negedge clk);
    check("a_b2_tdata", 256'(a_tdata), 256'h78);
    check("a_b2_tkeep", 256'(a_tkeep), 256'h01);
    check("a_b2_tstrb", 256'(a_tstrb), 256'h01);
    check("a_b2_tlast", 256'(a_tlast), 256'(1));
    check("a_b2_beat_idx", 256'(a_beat_idx), 256'(2));
    @(negedge clk);
    check("a_done", 256'(a_done), 256'(1));
    check("a_tvalid_end", 256'(a_tvalid), 256'(0));

    // No checksum, 64 bytes on 32-byte beats: valid one edge after start.
    for (int i = 0; i < 64; i++) b_msg[i*8 +: 8] = 8'(i + 16);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    check("b_lat_n1", 256'(b_tvalid), 256'(1));
    check("b_b0_tdata", b_tdata, b_msg[255:0]);
    check("b_b0_tkeep", 256'(b_tkeep), 256'hFFFFFFFF);
    check("b_b0_tlast", 256'(b_tlast), 256'(0));
    @(negedge clk);
    check("b_b1_tdata", b_tdata, b_msg[511:256]);
    check("b_b1_tkeep", 256'(b_tkeep), 256'hFFFFFFFF);
    check("b_b1_tlast", 256'(b_tlast), 256'(1));
    check("b_b1_beat_idx", 256'(b_beat_idx), 256'(1));
    @(negedge clk);
    check("b_done", 256'(b_done), 256'(1));
    check("b_busy_end", 256'(b_busy), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/msg_axis_framer.md
Name: msg_axis_framer

Overview:
- Parametrised successor to the fixed 79-byte order-message serializer. It captures a flat message vector on a start pulse and optionally appends an 8-bit additive checksum byte.
- The message streams out as AXI4-Stream beats of configurable width with full tready backpressure and an exact last-beat tkeep.
- Sits between the order-message field assembler and the TX MAC/UDP stream mux.

Parameters:
DATA_W, 256, tdata width in bits; multiple of 8, min 32; BPB = DATA_W/8 bytes per beat
MSG_BYTES, 79, message bytes before checksum; min 1
CHK_EN, 1, 1 = append checksum byte, 0 = no checksum
Derived: T = MSG_BYTES+CHK_EN; NBEATS = ceil(T/BPB); BIDX_W = max(1, clog2(NBEATS))

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request; samples msg
msg  in  MSG_BYTES*8  message; byte i = msg[8i+7:8i], byte 0 sent first
busy  out  1  high from accepted start until final handshake completes
done  out  1  one-cycle pulse after final handshake
tready  in  1  AXIS sink ready
tvalid  out  1  AXIS valid
tdata  out  DATA_W  AXIS data; stream byte j of beat b = message byte b*BPB+j on lane j
tkeep  out  BPB  byte-valid mask
tstrb  out  BPB  always equal to tkeep
tlast  out  1  high on beat NBEATS-1
beat_idx  out  BIDX_W  index of the beat currently presented

Behaviour:
- Async reset values: state IDLE; busy, done, tvalid, tlast = 0; tdata, tkeep, tstrb, beat_idx = 0; checksum accumulator = 0.
- FSM states: IDLE, CALC, SEND.
- IDLE, start=1:
  - Register msg into the internal buffer; clear the accumulator; beat_idx = 0; busy = 1.
  - Go to CALC if CHK_EN=1, otherwise go to SEND.
- IDLE, start=0: no action.
- CALC runs exactly NBEATS cycles:
  - Each cycle adds the message bytes of one beat slice into the 8-bit accumulator (mod 256; the checksum lane is excluded).
  - After the final slice, write the accumulator into buffer byte MSG_BYTES, then go to SEND.
- SEND:
  - tvalid = 1, tdata = buffer slice beat_idx.
  - Non-last beats: tkeep all ones.
  - Last beat: tkeep low R bits set, where R = T mod BPB; R = 0 means all ones.
  - Lanes with tkeep = 0 carry 0x00.
- Latency: first tvalid appears NBEATS+1 rising edges after the start edge when CHK_EN=1, and 1 edge after when CHK_EN=0.
- Handshake: a beat advances only when tvalid && tready. While tvalid && !tready, tdata, tkeep, tlast and beat_idx hold stable. tvalid never drops before the handshake.
- Final handshake on the tlast beat:
  - Next cycle: tvalid = 0, tlast = 0, busy = 0, done = 1 for one cycle, state IDLE.
  - tdata and tkeep return to 0.
- start while busy (CALC or SEND) is ignored; msg is not resampled.
- start in the done cycle is accepted, because the state is already IDLE.
- Reset mid-CALC or mid-SEND: all outputs drop immediately (async). The partial frame is abandoned; there is no resume.
- Checksum arithmetic: unsigned sum of all MSG_BYTES bytes, truncated to 8 bits.

Decomposition:
- Package msg_axis_pkg:
  - state enum (IDLE, CALC, SEND)
  - function ceil_div
  - function last_keep(T, BPB) returning the mask
  - constant CHK_W = 8
- Sub-module byte_sum_acc:
  - parametrised by BPB; sums one beat slice with a lane-valid mask into an 8-bit accumulator.
  - Reused by the RX checksum checker.

Test Plan:
- Default params, msg all bytes 0x01, tready=1:
  - 3 beats.
  - Beat 2: tkeep=0x0000FFFF, tdata[127:120]=0x4F, tlast=1.
  - done pulses 1 cycle after beat 2.
- Default params, all bytes 0xFF -> checksum byte 0xB1; lanes 16..31 of beat 2 read 0x00.
- tready low for 2 cycles while beat 1 is presented -> tdata and beat_idx=1 held constant, no skipped or duplicated beat, total 3 handshakes.
- start pulsed again during CALC and during SEND with a different msg -> ignored; output frame matches the first msg; busy stays high throughout.
- resetn low while beat 1 is pending -> tvalid, busy and tlast go to 0 immediately. A fresh start after release produces a complete 3-beat frame.
- Variants:
  - DATA_W=64, MSG_BYTES=16, CHK_EN=1, bytes 0..15 -> 3 beats, last tkeep=0x01, checksum byte 0x78.
  - DATA_W=256, MSG_BYTES=64, CHK_EN=0 -> 2 beats, both tkeep all ones, first tvalid 1 cycle after start.
